// File: rtl/seq_detect_param_if.sv
// seq_detect_param_if
// Bundles the configuration, serial-input and result signals of seq_detect_param.
//   master : stimulus side, drives configuration and bits, observes results
//   slave  : detector side
//   cfg_we/cfg_pattern/cfg_len/cfg_overlap : one-cycle configuration load
//   in_valid/serial_in                     : qualified serial bit stream
//   count_clr                              : synchronous match-counter clear
//   detected/match_count                   : registered match pulse, saturating count
interface seq_detect_param_if #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned CNT_W   = 8
);
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               in_valid;
  logic               serial_in;
  logic               count_clr;
  logic               detected;
  logic [CNT_W-1:0]   match_count;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, in_valid, serial_in, count_clr,
    input  detected, match_count
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, in_valid, serial_in, count_clr,
    output detected, match_count
  );
endinterface

// File: rtl/seq_detect_param.sv
// seq_detect_param
// Runtime-programmable serial pattern detector. Compares the last len_q accepted bits
// against a loaded pattern (first received bit = pattern[len-1]) in overlapping or
// non-overlapping mode, emitting a registered one-cycle pulse and a saturating count.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_detect_param_if slave modport (config, serial input, results)
module seq_detect_param #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_detect_param_if.slave  bus
);

  localparam logic [LEN_W-1:0] MaxLenL = LEN_W'(MAX_LEN);

  // Registered state
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_det;
  logic [CNT_W-1:0]   r_cnt;

  // Next-state and datapath wires
  logic [MAX_LEN-1:0] w_pat_nxt;
  logic [LEN_W-1:0]   w_len_nxt;
  logic               w_ovl_nxt;
  logic [MAX_LEN-1:0] w_hist_nxt;
  logic [LEN_W-1:0]   w_fill_nxt;
  logic               w_det_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  logic [MAX_LEN-1:0] w_hist_sh;
  logic [LEN_W-1:0]   w_fill_inc;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W-1:0]   w_cfg_len;
  logic               w_accept;
  logic               w_match;

  always_comb begin
    w_cfg_len  = (bus.cfg_len > MaxLenL) ? MaxLenL : bus.cfg_len;
    w_accept   = bus.in_valid && !bus.cfg_we;
    w_hist_sh  = {r_hist[MAX_LEN-2:0], bus.serial_in};
    // fill never exceeds len_q, so equality is the saturation test
    w_fill_inc = (r_fill == r_len) ? r_len : r_fill + 1'b1;
    // Only the low len_q bits of history and pattern take part in the compare
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (LEN_W'(i) < r_len);
    end
    w_match = w_accept && (w_fill_inc == r_len) && (r_len != '0) &&
              ((w_hist_sh & w_mask) == (r_pat & w_mask));
  end

  always_comb begin
    w_pat_nxt  = r_pat;
    w_len_nxt  = r_len;
    w_ovl_nxt  = r_ovl;
    w_hist_nxt = r_hist;
    w_fill_nxt = r_fill;
    w_det_nxt  = 1'b0;
    w_cnt_nxt  = r_cnt;

    if (bus.cfg_we) begin
      // A concurrent in_valid bit is deliberately dropped
      w_pat_nxt  = bus.cfg_pattern;
      w_len_nxt  = w_cfg_len;
      w_ovl_nxt  = bus.cfg_overlap;
      w_hist_nxt = '0;
      w_fill_nxt = '0;
    end else if (bus.in_valid) begin
      w_hist_nxt = w_hist_sh;
      // Non-overlap mode demands len_q fresh bits after each match
      w_fill_nxt = (w_match && !r_ovl) ? '0 : w_fill_inc;
      w_det_nxt  = w_match;
    end

    if (bus.count_clr) begin
      // A match coinciding with a clear is still counted
      w_cnt_nxt = w_match ? CNT_W'(1) : '0;
    end else if (w_match && (r_cnt != '1)) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat  <= MAX_LEN'(3);
      r_len  <= LEN_W'(3);
      r_ovl  <= 1'b0;
      r_hist <= '0;
      r_fill <= '0;
      r_det  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_pat  <= w_pat_nxt;
      r_len  <= w_len_nxt;
      r_ovl  <= w_ovl_nxt;
      r_hist <= w_hist_nxt;
      r_fill <= w_fill_nxt;
      r_det  <= w_det_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign bus.detected    = r_det;
  assign bus.match_count = r_cnt;

endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param
// Drives two detectors (CNT_W=8 and CNT_W=2) with identical stimulus and compares both
// against a bit-queue reference model after every clock.
module tb_seq_detect_param;

  localparam int unsigned MaxLen = 8;
  localparam int unsigned LenW   = 4;

  logic clk;
  logic rst_n;

  seq_detect_param_if #(.MAX_LEN(MaxLen), .LEN_W(LenW), .CNT_W(8)) if_a ();
  seq_detect_param_if #(.MAX_LEN(MaxLen), .LEN_W(LenW), .CNT_W(2)) if_b ();

  seq_detect_param #(.MAX_LEN(MaxLen), .LEN_W(LenW), .CNT_W(8)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
  );

  seq_detect_param #(.MAX_LEN(MaxLen), .LEN_W(LenW), .CNT_W(2)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: configuration, accepted bits, count of fresh bits since restart
  logic [31:0] m_pat;
  int          m_len;
  bit          m_ovl;
  int          m_bits[$];
  int          m_fresh;
  int          exp_det;
  int          exp_cnt_a;
  int          exp_cnt_b;

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_pat     = 32'b011;
    m_len     = 3;
    m_ovl     = 1'b0;
    m_bits.delete();
    m_fresh   = 0;
    exp_det   = 0;
    exp_cnt_a = 0;
    exp_cnt_b = 0;
  endtask

  task automatic model_update(input logic we, input logic [7:0] pat, input logic [3:0] len,
                              input logic ovl, input logic v, input logic b, input logic clr);
    bit hit;
    hit = 1'b0;
    if (we) begin
      m_pat   = {24'd0, pat};
      m_len   = (int'(len) > MaxLen) ? MaxLen : int'(len);
      m_ovl   = ovl;
      m_bits.delete();
      m_fresh = 0;
    end else if (v) begin
      m_bits.push_back(int'(b));
      if (m_bits.size() > 40) void'(m_bits.pop_front());
      if (m_fresh < m_len) m_fresh++;
      if (m_len > 0 && m_fresh == m_len) begin
        hit = 1'b1;
        // Newest bit corresponds to pattern[0], oldest of the window to pattern[len-1]
        for (int k = 0; k < m_len; k++) begin
          if (m_bits[m_bits.size() - 1 - k] != int'(m_pat[k])) hit = 1'b0;
        end
      end
      if (hit && !m_ovl) m_fresh = 0;
    end
    exp_det = hit ? 1 : 0;
    if (clr) begin
      exp_cnt_a = hit ? 1 : 0;
      exp_cnt_b = hit ? 1 : 0;
    end else if (hit) begin
      if (exp_cnt_a < 255) exp_cnt_a++;
      if (exp_cnt_b < 3) exp_cnt_b++;
    end
  endtask

  task automatic drive(input logic we, input logic [7:0] pat, input logic [3:0] len,
                       input logic ovl, input logic v, input logic b, input logic clr);
    if_a.cfg_we = we;  if_a.cfg_pattern = pat; if_a.cfg_len = len; if_a.cfg_overlap = ovl;
    if_a.in_valid = v; if_a.serial_in = b;     if_a.count_clr = clr;
    if_b.cfg_we = we;  if_b.cfg_pattern = pat; if_b.cfg_len = len; if_b.cfg_overlap = ovl;
    if_b.in_valid = v; if_b.serial_in = b;     if_b.count_clr = clr;
  endtask

  // One clock: apply inputs, advance model, sample 1 time unit after the edge
  task automatic step(input logic we, input logic [7:0] pat, input logic [3:0] len,
                      input logic ovl, input logic v, input logic b, input logic clr);
    drive(we, pat, len, ovl, v, b, clr);
    model_update(we, pat, len, ovl, v, b, clr);
    @(posedge clk);
    #1;
    chk("det_a", int'(if_a.detected), exp_det);
    chk("det_b", int'(if_b.detected), exp_det);
    chk("cnt_a", int'(if_a.match_count), exp_cnt_a);
    chk("cnt_b", int'(if_b.match_count), exp_cnt_b);
    drive(1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic bit_in(input logic b);
    step(1'b0, 8'd0, 4'd0, 1'b0, 1'b1, b, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    // Clear the counters alongside the load so each scenario starts from zero
    step(1'b1, pat, len, ovl, 1'b0, 1'b0, 1'b1);
  endtask

  logic [5:0] seq_a;
  logic [6:0] seq_b;
  int         pulses;

  initial begin
    seq_a = 6'b011011;
    seq_b = 7'b1011011;
    drive(1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_det_a", int'(if_a.detected), 0);
    chk("rst_cnt_a", int'(if_a.match_count), 0);
    chk("rst_cnt_b", int'(if_b.match_count), 0);
    rst_n = 1'b1;

    // Reset configuration 'b011, len 3: pulses after bits 3 and 6
    for (int i = 5; i >= 0; i--) bit_in(seq_a[i]);
    chk("t1_cnt", int'(if_a.match_count), 2);

    // 'b1011 len 4 overlapping: matches after bits 4 and 7
    cfg(8'b1011, 4'd4, 1'b1);
    for (int i = 6; i >= 0; i--) bit_in(seq_b[i]);
    chk("t2_cnt", int'(if_a.match_count), 2);

    // Same stream non-overlapping: a single match
    cfg(8'b1011, 4'd4, 1'b0);
    for (int i = 6; i >= 0; i--) bit_in(seq_b[i]);
    chk("t3_cnt", int'(if_a.match_count), 1);

    // 'b011 with 3-cycle idle gaps; upper pattern bits must be ignored
    cfg(8'b1111_0011, 4'd3, 1'b0);
    pulses = 0;
    for (int i = 2; i >= 0; i--) begin
      bit_in((i == 2) ? 1'b0 : 1'b1);
      pulses += int'(if_a.detected);
      if (i != 0) begin
        repeat (3) begin
          idle();
          pulses += int'(if_a.detected);
        end
      end
    end
    chk("t4_pulses", pulses, 1);

    // len 1, pattern '1', overlap: CNT_W=2 instance saturates at 3
    cfg(8'b1, 4'd1, 1'b1);
    repeat (6) bit_in(1'b1);
    chk("t5_sat_b", int'(if_b.match_count), 3);
    chk("t5_cnt_a", int'(if_a.match_count), 6);
    step(1'b0, 8'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t5_clr_b", int'(if_b.match_count), 1);

    // len 0 disables detection
    cfg(8'hFF, 4'd0, 1'b1);
    repeat (20) bit_in(1'($urandom_range(0, 1)));

    // Asynchronous reset mid-stream
    bit_in(1'b1);
    drive(1'b0, 8'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_det_a", int'(if_a.detected), 0);
    chk("mid_rst_cnt_a", int'(if_a.match_count), 0);
    chk("mid_rst_cnt_b", int'(if_b.match_count), 0);
    model_reset();
    drive(1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    // Configuration must be back to 'b011 len 3
    bit_in(1'b0);
    bit_in(1'b1);
    bit_in(1'b1);
    chk("post_rst_cfg", int'(if_a.detected), 1);

    // Randomised traffic, including clamped lengths and cfg/valid collisions
    for (int n = 0; n < 600; n++) begin
      logic we, ovl, v, b, clr;
      logic [7:0] pat;
      logic [3:0] len;
      we  = ($urandom_range(0, 39) == 0);
      pat = 8'($urandom);
      len = 4'($urandom_range(0, 10));
      ovl = 1'($urandom_range(0, 1));
      v   = ($urandom_range(0, 3) != 0);
      b   = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 49) == 0);
      if (we && $urandom_range(0, 1) == 1) len = 4'($urandom_range(1, 3));
      step(we, pat, len, ovl, v, b, clr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised, runtime-programmable serial pattern detector for the FSM library. Compares a qualified serial bit stream against a pattern of 1..MAX_LEN bits loaded through a configuration port, in overlapping or non-overlapping mode. Emits a one-cycle registered `detected` pulse per match and keeps a saturating match counter. It sits between a serial front-end (UART/deserialiser bit stream) and control logic that reacts to framing or sync words.

## Interface
- `MAX_LEN`, default 8, is the maximum pattern length in bits. Legal range is 2..32.
- `LEN_W`, default `$clog2(MAX_LEN+1)`, is the width of the length field.
- `CNT_W`, default 8, is the width of the match counter.

- `clk`  in  1  is the single clock. All logic is rising-edge.
- `rst_n`  in  1  is the asynchronous, active-low reset.
- `cfg_we`  in  1  is a one-cycle strobe that loads the configuration.
- `cfg_pattern`  in  MAX_LEN  is the pattern. Bit `[len-1]` is the first bit received and bit `[0]` is the last.
- `cfg_len`  in  LEN_W  is the pattern length in bits.
- `cfg_overlap`  in  1  selects the mode: 1 = overlapping matches allowed, 0 = history restarts after each match.
- `in_valid`  in  1  qualifies `serial_in`. Bits are consumed only when `in_valid` is high.
- `serial_in`  in  1  is the serial data bit.
- `count_clr`  in  1  is a synchronous clear of `match_count`.
- `detected`  out  1  is a registered one-cycle match pulse.
- `match_count`  out  CNT_W  is the saturating count of matches.

## Operation
**Internal state**
- Registered configuration: `pat_q`, `len_q`, `ovl_q`.
- History shift register `hist[MAX_LEN-1:0]`.
- Fill counter `fill`, ranging 0..`len_q`.

**Reset**
- `pat_q` = 'b011, `len_q` = 3, `ovl_q` = 0.
- `hist` = 0, `fill` = 0, `detected` = 0, `match_count` = 0.

**Configuration load** (`cfg_we`=1)
- Latches the pattern, length and mode.
- Clears `hist` and `fill`, and forces `detected` to 0 on the next cycle.
- `cfg_len` > MAX_LEN is clamped to MAX_LEN.
- `cfg_len` = 0 disables detection: bits are still shifted, but no match is ever reported.
- Pattern bits at and above `len` are ignored.

**Bit accepted** (`in_valid`=1, `cfg_we`=0)
- `hist_n` = {hist[MAX_LEN-2:0], serial_in}.
- `fill_n` = min(fill+1, len_q).
- A match occurs when all three hold: `fill_n` == `len_q`, `len_q` != 0, and `hist_n[len_q-1:0]` == `pat_q[len_q-1:0]`.
- On a match: `detected` <= 1 and `match_count` increments, saturating at 2^CNT_W−1 with no wrap.
- After a match in non-overlap mode (`ovl_q`=0): `fill` <= 0, so a new match requires `len_q` fresh bits. `hist` still shifts.
- After a match in overlap mode (`ovl_q`=1): `fill` stays at `len_q`, so the very next bit may complete another match.

**Idle** (`in_valid`=0)
- `hist` and `fill` hold.
- `detected` <= 0.

**Priorities**
- `cfg_we` together with `in_valid`: the configuration is loaded and the bit is discarded.
- `count_clr` together with a match: `match_count` becomes 1 (no event is lost).
- `count_clr` alone: `match_count` becomes 0.

**Reset mid-operation**
- All state, including the configuration, returns to its reset values immediately (asynchronous).
- Any partial match is lost.

## Timing
- `detected` goes high on the clock edge that samples the final pattern bit. It is visible the cycle after that bit is presented, i.e. one cycle of latency.
- `detected` is a single-cycle pulse. In overlap mode with a continuously matching stream (pattern all ones, input all ones) it stays high on consecutive cycles.
- `match_count` updates on the same edge as `detected` rises.
- `cfg_we` takes effect on the next edge. The first bit counted toward a match under the new configuration is the first bit accepted with `in_valid`=1 on a later cycle.
- There is no backpressure: `in_valid` may be high on every cycle.
- Throughput is one bit per clock.

## Test plan
- Reset configuration: feed 0,1,1,0,1,1 with `in_valid`=1. Required: `detected` pulses after the 3rd and 6th bits, and `match_count`=2.
- Load pattern 'b1011, len 4, overlap 1; feed 1,0,1,1,0,1,1. Required: `detected` after bits 4 and 7, and `match_count`=2.
- Same stream with overlap 0. Required: a single `detected` after bit 4, and `match_count`=1.
- Insert `in_valid`=0 gaps of 3 cycles between every bit of 0,1,1 (reset configuration). Required: exactly one `detected`, aligned to the final valid bit, and no pulses during gaps.
- Set CNT_W=2, pattern '1', len 1, overlap 1; feed six 1s. Required: `match_count` saturates at 3. Then assert `count_clr` on the same cycle as a match. Required: `match_count`=1.
- Drive `cfg_we` with `cfg_len`=0 and feed 20 random bits. Required: `detected` stays 0. Then assert `rst_n`=0 mid-stream. Required: all outputs are 0 immediately, and the configuration reverts to 'b011, len 3.
